// File: rtl/usb_rx_sched.sv
// usb_rx_sched: receive-path controller for the USB host transceiver.
// Arms the receiver front end for a data or handshake packet, enforces the
// bus-turnaround timeout and receive watchdog, acknowledges EOP errors,
// retries failed data packets and reports one result code per request.
// Optional build macro USB_RX_STATS_EN adds saturating failure counters.
module usb_rx_sched #(
    parameter int TIMEOUT   = 255,
    parameter int RX_WDOG   = 128,
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_type,
    output logic       req_ready,
    input  logic       req_cancel,
    output logic       arm_data,
    output logic       arm_hshake,
    output logic       rx_abort,
    input  logic       got_sync,
    input  logic       rx_done,
    input  logic       eop_err,
    input  logic       crc_ok,
    output logic       eop_ack,
    output logic       res_valid,
    output logic [2:0] res_code,
`ifdef USB_RX_STATS_EN
    input  logic       stat_clr,
    output logic [7:0] stat_timeout,
    output logic [7:0] stat_eop,
    output logic [7:0] stat_crc,
`endif
    output logic [2:0] res_tries
);

    localparam int TMAX1 = (TIMEOUT > RX_WDOG) ? TIMEOUT : RX_WDOG;
    localparam int TMAX  = (TMAX1 > BACKOFF) ? TMAX1 : BACKOFF;
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WD_LAST = TW'(RX_WDOG - 1);
    localparam logic [TW-1:0] BO_LAST = TW'(BACKOFF - 1);
    localparam logic [2:0]    TRY_MAX = 3'(MAX_RETRY);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_LISTEN  = 3'd2;
    localparam logic [2:0] S_RECV    = 3'd3;
    localparam logic [2:0] S_ACKERR  = 3'd4;
    localparam logic [2:0] S_BACKOFF = 3'd5;
    localparam logic [2:0] S_REPORT  = 3'd6;

    localparam logic [2:0] C_OK      = 3'd0;
    localparam logic [2:0] C_TIMEOUT = 3'd1;
    localparam logic [2:0] C_EOP     = 3'd2;
    localparam logic [2:0] C_CRC     = 3'd3;
    localparam logic [2:0] C_ABORT   = 3'd4;

    logic [2:0]    state, nxt_state;
    logic          rtype;
    logic [2:0]    tries, nxt_tries;
    logic [2:0]    code, nxt_code;
    logic [TW-1:0] timer;
    logic          tmr_clr;
    logic          fail;
    logic [2:0]    fail_code;
    logic          abort_wd;
    logic          cancel_act;
    logic          arm_lvl;

    // Cancel is honoured only while a request is actually in flight.
    assign cancel_act = req_cancel && (state != S_IDLE) && (state != S_REPORT);

    // Next-state logic; cancel overrides every other event of the cycle.
    always_comb begin
        nxt_state = state;
        nxt_tries = tries;
        nxt_code  = code;
        tmr_clr   = 1'b0;
        fail      = 1'b0;
        fail_code = code;
        abort_wd  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    nxt_state = S_ARM;
                    nxt_tries = 3'd1;
                end
            end
            S_ARM: begin
                nxt_state = S_LISTEN;
                tmr_clr   = 1'b1;
            end
            S_LISTEN: begin
                if (got_sync) begin
                    nxt_state = S_RECV;
                    tmr_clr   = 1'b1;
                end else if (timer == TO_LAST) begin
                    fail      = 1'b1;
                    fail_code = C_TIMEOUT;
                end
            end
            S_RECV: begin
                if (eop_err) begin
                    nxt_state = S_ACKERR;
                    nxt_code  = C_EOP;
                end else if (rx_done && crc_ok) begin
                    nxt_state = S_REPORT;
                    nxt_code  = C_OK;
                end else if (rx_done) begin
                    fail      = 1'b1;
                    fail_code = C_CRC;
                end else if (timer == WD_LAST) begin
                    fail      = 1'b1;
                    fail_code = C_EOP;
                    abort_wd  = 1'b1;
                end
            end
            S_ACKERR: begin
                fail      = 1'b1;
                fail_code = C_EOP;
            end
            S_BACKOFF: begin
                if (timer == BO_LAST) begin
                    nxt_state = S_ARM;
                    if (tries < TRY_MAX) nxt_tries = tries + 3'd1;
                end
            end
            S_REPORT: nxt_state = S_IDLE;
            default:  nxt_state = S_IDLE;
        endcase

        // Only data packets get another attempt, and only while tries remain.
        if (fail) begin
            nxt_code = fail_code;
            if (!rtype && (tries < TRY_MAX)) begin
                nxt_state = S_BACKOFF;
                tmr_clr   = 1'b1;
            end else begin
                nxt_state = S_REPORT;
            end
        end

        if (cancel_act) begin
            nxt_state = S_REPORT;
            nxt_code  = C_ABORT;
            abort_wd  = 1'b0;
        end
    end

    // State, latched request type, try counter and result code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rtype <= 1'b0;
            tries <= 3'd0;
            code  <= C_OK;
        end else begin
            state <= nxt_state;
            tries <= nxt_tries;
            code  <= nxt_code;
            if (state == S_IDLE && req_valid) rtype <= req_type;
        end
    end

    // Shared saturating timer for turnaround, watchdog and backoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (tmr_clr) begin
            timer <= '0;
        end else if ((state == S_LISTEN || state == S_RECV || state == S_BACKOFF)
                     && (timer != {TW{1'b1}})) begin
            timer <= timer + 1'b1;
        end
    end

    // Arm level is dropped in the same cycle a cancel is seen.
    assign arm_lvl    = (state == S_ARM || state == S_LISTEN || state == S_RECV) && !cancel_act;
    assign arm_data   = arm_lvl && !rtype;
    assign arm_hshake = arm_lvl && rtype;
    assign rx_abort   = cancel_act || abort_wd;
    assign eop_ack    = (state == S_ACKERR) && !cancel_act;
    assign req_ready  = (state == S_IDLE);
    assign res_valid  = (state == S_REPORT);
    assign res_code   = res_valid ? code  : 3'd0;
    assign res_tries  = res_valid ? tries : 3'd0;

`ifdef USB_RX_STATS_EN
    logic inc_to, inc_eop, inc_crc;
    assign inc_to  = fail && !cancel_act && (fail_code == C_TIMEOUT);
    assign inc_eop = fail && !cancel_act && (fail_code == C_EOP);
    assign inc_crc = fail && !cancel_act && (fail_code == C_CRC);

    // Per-attempt failure counters, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_timeout <= 8'd0;
            stat_eop     <= 8'd0;
            stat_crc     <= 8'd0;
        end else begin
            if (inc_to  && stat_timeout != 8'hff) stat_timeout <= stat_timeout + 8'd1;
            if (inc_eop && stat_eop     != 8'hff) stat_eop     <= stat_eop + 8'd1;
            if (inc_crc && stat_crc     != 8'hff) stat_crc     <= stat_crc + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_usb_rx_sched.sv
// tb_usb_rx_sched: directed self-checking bench for usb_rx_sched with a
// result scoreboard. Build with USB_RX_STATS_EN to also cover the counters.
module tb_usb_rx_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_type = 1'b0, req_cancel = 1'b0;
    logic got_sync = 1'b0, rx_done = 1'b0, eop_err = 1'b0, crc_ok = 1'b0;
    logic req_ready, arm_data, arm_hshake, rx_abort, eop_ack, res_valid;
    logic [2:0] res_code, res_tries;
`ifdef USB_RX_STATS_EN
    logic stat_clr = 1'b0;
    logic [7:0] stat_timeout, stat_eop, stat_crc;
`endif

    typedef struct packed {
        logic [2:0] code;
        logic [2:0] tries;
    } res_t;

    res_t sbq[$];
    res_t exp_r;
    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int abort_cnt = 0;
    bit excl_bad = 1'b0;

    always #5 clk = ~clk;

    usb_rx_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_type(req_type), .req_ready(req_ready),
        .req_cancel(req_cancel),
        .arm_data(arm_data), .arm_hshake(arm_hshake), .rx_abort(rx_abort),
        .got_sync(got_sync), .rx_done(rx_done), .eop_err(eop_err), .crc_ok(crc_ok),
        .eop_ack(eop_ack), .res_valid(res_valid), .res_code(res_code),
`ifdef USB_RX_STATS_EN
        .stat_clr(stat_clr), .stat_timeout(stat_timeout),
        .stat_eop(stat_eop), .stat_crc(stat_crc),
`endif
        .res_tries(res_tries)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic [2:0] c, input logic [2:0] t);
        res_t r;
        r.code  = c;
        r.tries = t;
        return r;
    endfunction

    // Monitor: pop the scoreboard on every result strobe, count pulses.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (eop_ack)  ack_cnt++;
            if (rx_abort) abort_cnt++;
            if ((eop_ack && rx_abort) || (arm_data && arm_hshake)) excl_bad = 1'b1;
            if (res_valid) begin
                if (sbq.size() == 0) begin
                    chk("res_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_r = sbq.pop_front();
                    chk("res_code", {29'd0, res_code}, {29'd0, exp_r.code});
                    chk("res_tries", {29'd0, res_tries}, {29'd0, exp_r.tries});
                end
            end
        end
    end

    task automatic nx();
        @(negedge clk);
    endtask

    // Issue a request from IDLE; returns settled in the ARM cycle.
    task automatic req(input logic t);
        req_valid = 1'b1;
        req_type  = t;
        #1 chk("req_ready", {31'd0, req_ready}, 32'd1);
        nx();
        req_valid = 1'b0;
        #1;
    endtask

    // From ARM: sync next cycle, n RECV cycles, then rx_done with crc/err.
    task automatic sync_recv(input int n, input logic crc, input logic err);
        nx(); got_sync = 1'b1;
        nx(); got_sync = 1'b0;
        repeat (n) nx();
        rx_done = 1'b1; crc_ok = crc; eop_err = err;
        nx(); rx_done = 1'b0; crc_ok = 1'b0;
        #1;
    endtask

    // Count arm-low cycles until the next ARM (bounded).
    task automatic wait_arm(output int gap);
        gap = 0;
        while (!(arm_data || arm_hshake) && gap < 64) begin
            nx(); #1; gap++;
        end
    endtask

    initial begin
        int gap, a0, b0, cnt, bad;
        repeat (2) nx();
        rst = 1'b0;
        #1;
        chk("reset_outs", {29'd0, req_ready, arm_data, arm_hshake, rx_abort, eop_ack, res_valid, res_code, res_tries},
            {29'd0, 1'b1, 5'd0, 6'd0});
`ifdef USB_RX_STATS_EN
        chk("reset_stats", {8'd0, stat_timeout, stat_eop, stat_crc}, 32'd0);
`endif

        // 1: data packet, good CRC
        req(1'b0);
        chk("t1_arm_data", {30'd0, arm_data, arm_hshake}, 32'd2);
        bad = 0;
        for (int i = 0; i < 10; i++) begin nx(); #1; if (!arm_data) bad++; end
        got_sync = 1'b1;
        nx(); got_sync = 1'b0;
        for (int i = 0; i < 69; i++) begin nx(); #1; if (!arm_data) bad++; end
        rx_done = 1'b1; crc_ok = 1'b1;
        #1 chk("t1_arm_at_done", {31'd0, arm_data}, 32'd1);
        chk("t1_arm_held", bad, 32'd0);
        sbq.push_back(mk(3'd0, 3'd1));
        nx(); rx_done = 1'b0; crc_ok = 1'b0;
        #1 chk("t1_arm_report", {31'd0, arm_data}, 32'd0);
        chk("t1_res_valid", {31'd0, res_valid}, 32'd1);
        nx(); #1 chk("t1_idle", {31'd0, req_ready}, 32'd1);

        // 2: handshake timeout, no retry
        req(1'b1);
        chk("t2_arm_hs", {30'd0, arm_data, arm_hshake}, 32'd1);
        nx(); #1;
        sbq.push_back(mk(3'd1, 3'd1));
        cnt = 0; bad = 0;
        for (int i = 1; i < 255; i++) begin
            nx(); #1;
            if (res_valid) cnt++;
            if (arm_data) bad++;
        end
        chk("t2_no_early_res", cnt, 32'd0);
        chk("t2_arm_data_never", bad, 32'd0);
        nx(); #1 chk("t2_timeout_exact", {31'd0, res_valid}, 32'd1);
`ifdef USB_RX_STATS_EN
        chk("t2_stat_to", {24'd0, stat_timeout}, 32'd1);
`endif
        nx(); #1;

        // 3: two CRC failures then success
        req(1'b0);
        sbq.push_back(mk(3'd0, 3'd3));
        sync_recv(5, 1'b0, 1'b0);
        wait_arm(gap);
        chk("t3_backoff1", gap, 32'd16);
        sync_recv(5, 1'b0, 1'b0);
        wait_arm(gap);
        chk("t3_backoff2", gap, 32'd16);
        sync_recv(5, 1'b1, 1'b0);
        chk("t3_res_valid", {31'd0, res_valid}, 32'd1);
`ifdef USB_RX_STATS_EN
        chk("t3_stat_crc", {24'd0, stat_crc}, 32'd2);
`endif
        nx(); #1;

        // 4: eop_err together with rx_done on every attempt
        a0 = ack_cnt;
        req(1'b0);
        sbq.push_back(mk(3'd2, 3'd3));
        for (int k = 0; k < 3; k++) begin
            sync_recv(5, 1'b0, 1'b1);
            chk("t4_eop_ack", {30'd0, eop_ack, rx_abort}, 32'd2);
            eop_err = 1'b0;
            nx(); #1;
            if (k < 2) begin
                wait_arm(gap);
                chk("t4_backoff", gap, 32'd16);
            end
        end
        chk("t4_res_valid", {31'd0, res_valid}, 32'd1);
        nx(); #1;
        chk("t4_ack_count", ack_cnt - a0, 32'd3);
`ifdef USB_RX_STATS_EN
        chk("t4_stat_eop", {24'd0, stat_eop}, 32'd3);
        stat_clr = 1'b1;
        nx(); stat_clr = 1'b0;
        #1 chk("t4_stat_clr", {8'd0, stat_timeout, stat_eop, stat_crc}, 32'd0);
`endif

        // 5: cancel during RECV
        b0 = abort_cnt;
        req(1'b0);
        nx(); got_sync = 1'b1;
        nx(); got_sync = 1'b0;
        repeat (5) nx();
        req_cancel = 1'b1;
        #1 chk("t5_abort", {30'd0, rx_abort, arm_data}, 32'd2);
        sbq.push_back(mk(3'd4, 3'd1));
        nx(); req_cancel = 1'b0;
        #1 chk("t5_report", {30'd0, rx_abort, res_valid}, 32'd1);
        nx(); #1 chk("t5_ready", {31'd0, req_ready}, 32'd1);
        chk("t5_abort_once", abort_cnt - b0, 32'd1);

        // 6: receive watchdog on a handshake
        req(1'b1);
        nx(); got_sync = 1'b1;
        nx(); got_sync = 1'b0;
        #1;
        sbq.push_back(mk(3'd2, 3'd1));
        cnt = 0;
        while (!rx_abort && cnt < 300) begin nx(); #1; cnt++; end
        chk("t6_wdog_cycle", cnt, 32'd127);
        nx(); #1 chk("t6_wdog_report", {30'd0, eop_ack, res_valid}, 32'd1);
        nx(); #1;

        // 7: got_sync on the last turnaround cycle wins over timeout
        req(1'b1);
        nx();
        repeat (254) nx();
        got_sync = 1'b1;
        sbq.push_back(mk(3'd0, 3'd1));
        nx(); got_sync = 1'b0;
        #1 chk("t7_sync_wins", {30'd0, arm_hshake, res_valid}, 32'd2);
        rx_done = 1'b1; crc_ok = 1'b1;
        nx(); rx_done = 1'b0; crc_ok = 1'b0;
        #1 chk("t7_res_valid", {31'd0, res_valid}, 32'd1);
        nx(); #1;

        // 8: reset mid-LISTEN, then a normal request
        b0 = abort_cnt;
        req(1'b1);
        repeat (20) nx();
        rst = 1'b1;
        nx(); rst = 1'b0;
        #1 chk("t8_reset_outs", {29'd0, req_ready, arm_data, arm_hshake, rx_abort, eop_ack, res_valid, res_code, res_tries},
               {29'd0, 1'b1, 5'd0, 6'd0});
        chk("t8_no_abort", abort_cnt - b0, 32'd0);
`ifdef USB_RX_STATS_EN
        chk("t8_stats_zero", {8'd0, stat_timeout, stat_eop, stat_crc}, 32'd0);
`endif
        req(1'b0);
        sbq.push_back(mk(3'd0, 3'd1));
        sync_recv(3, 1'b1, 1'b0);
        chk("t8_res_valid", {31'd0, res_valid}, 32'd1);
        repeat (3) nx();
        #3;

        chk("sb_empty", sbq.size(), 32'd0);
        chk("excl_rules", {31'd0, excl_bad}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_rx_sched.md
Name: usb_rx_sched

Overview:
- Receive-path controller for the USB host transceiver.
- Accepts "receive data" or "receive handshake" requests from the protocol FSM and arms the D+/D- receiver front end.
- Enforces the bus-turnaround timeout and a receive watchdog, and acknowledges EOP errors.
- Retries failed data packets, then reports a single result code upstream. Sits between the protocol FSM and the receive chain (DP/DM decoder, NRZI decoder, bit unstuffer, CRC checker).

Parameters:
- TIMEOUT, 255: cycles allowed from arming to sync detection.
- RX_WDOG, 128: cycles allowed from sync to packet completion.
- MAX_RETRY, 3: maximum data-packet attempts, including the first; must be 1..7.
- BACKOFF, 16: idle cycles between a failed attempt and the re-arm.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  receive request
- req_type  in  1  0 = data packet (64-bit payload), 1 = handshake
- req_ready  out  1  high only in IDLE
- req_cancel  in  1  abort the current request
- arm_data  out  1  level to receiver: expect data
- arm_hshake  out  1  level to receiver: expect handshake
- rx_abort  out  1  one-cycle pulse to every receive module
- got_sync  in  1  receiver found SYNC
- rx_done  in  1  receiver reached a good EOP (one-cycle pulse)
- eop_err  in  1  receiver EOP/overlength error (level, held until acknowledged)
- crc_ok  in  1  CRC result, valid in the cycle rx_done is high
- eop_ack  out  1  one-cycle acknowledge that clears the receiver error state
- res_valid  out  1  one-cycle result strobe
- res_code  out  3  0 OK, 1 TIMEOUT, 2 EOP_ERR, 3 CRC_ERR, 4 ABORTED
- res_tries  out  3  attempts used, 1..MAX_RETRY

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - state goes to IDLE.
  - All outputs are 0, except req_ready, which is 1 in the cycle after reset.
  - Timers and the try counter are 0.
  - Reset mid-packet does not pulse rx_abort; the receive modules share rst.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_type, set tries = 1, go to ARM.
- ARM (1 cycle):
  - Clear the timer.
  - Assert arm_data or arm_hshake per the latched type; the arm level stays high through ARM, LISTEN and RECV.
  - Go to LISTEN.
- LISTEN:
  - Timer increments each cycle.
  - got_sync: go to RECV and clear the timer.
  - Otherwise, timer == TIMEOUT-1: fail with code TIMEOUT.
  - got_sync wins over timeout when both occur in the same cycle.
- RECV:
  - Timer increments each cycle.
  - eop_err: go to ACKERR (code EOP_ERR).
  - Else rx_done with crc_ok = 1: success.
  - Else rx_done with crc_ok = 0: fail with code CRC_ERR.
  - Else timer == RX_WDOG-1: pulse rx_abort and fail with code EOP_ERR.
  - eop_err has priority over rx_done in the same cycle.
- ACKERR (1 cycle):
  - Drive eop_ack = 1, drop the arm level, then apply the fail rule.
- Fail rule:
  - Data request with tries < MAX_RETRY: go to BACKOFF, then ARM, and increment tries.
  - Otherwise go to REPORT with the failing code.
  - Handshake requests are never retried.
- BACKOFF:
  - Arm levels are low; count BACKOFF cycles, then go to ARM.
- REPORT (1 cycle):
  - res_valid = 1 with res_code and res_tries, then go to IDLE.
  - Success also reports through REPORT with code 0.
- req_cancel in any state except IDLE or REPORT:
  - Pulse rx_abort in that cycle, drop the arm level, go to REPORT with code ABORTED.
  - Cancel has priority over every other event in the same cycle.
- Counter rules:
  - Timer width is $clog2(max(TIMEOUT, RX_WDOG, BACKOFF)+1).
  - Timer saturates and never wraps.
  - tries never exceeds MAX_RETRY.
- Output rules:
  - rx_abort and eop_ack are never high in the same cycle.
  - arm_data and arm_hshake are never high together.

Optional Feature:
- Macro: USB_RX_STATS_EN.
- Defined:
  - Adds output ports stat_timeout, stat_eop and stat_crc (each 8 bits) and input stat_clr.
  - Each counter increments once per failed attempt of its type (retries included) and saturates at 255.
  - stat_clr or rst zeroes all three counters.
- Undefined:
  - The ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Data request, got_sync 10 cycles after ARM, rx_done with crc_ok = 1 after 70 cycles -> res_valid with code 0, tries 1; arm_data high from ARM until the cycle after rx_done.
- Handshake request, no got_sync -> res_code 1 exactly TIMEOUT cycles after LISTEN entry, tries 1; no retry, arm_data never set.
- Data request, first two attempts rx_done with crc_ok = 0, third attempt OK -> two 16-cycle BACKOFF gaps with arm low; result code 0, tries 3.
- Data request, eop_err and rx_done in the same cycle on every attempt -> eop_ack pulsed 3 times, result code 2, tries 3.
- req_cancel during RECV -> rx_abort single pulse in that cycle, res_code 4 next cycle, req_ready back to 1.
- rst asserted mid-LISTEN -> next cycle all outputs 0 except req_ready = 1; a new request completes normally; with USB_RX_STATS_EN defined, counters read 0.
